// File: rtl/harness_run_ctrl_pkg.sv
// harness_ctrl_pkg: shared op/state encodings and default widths for the run controller
package harness_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_STEP  = 2'd1,
        OP_RUN_N = 2'd2,
        OP_STOP  = 2'd3
    } op_e;

    localparam logic [1:0] ST_RST_HOLD = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;

    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/harness_run_ctrl_if.sv
// harness_run_ctrl_if: command valid/ready channel from the register block to the run controller
interface harness_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg, output cmd_ready);
endinterface

// File: rtl/harness_run_ctrl_counter.sv
// run_ctrl_counter: loadable down-counter flagging its last count; can be loaded as unbounded
module run_ctrl_counter #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         load_unb_i,
    input  logic         dec_i,
    output logic         last_o
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         unb_q, unb_d;

    // load wins over decrement; an unbounded count never moves
    always_comb begin
        cnt_d = load_i ? load_val_i : (dec_i && !unb_q) ? cnt_q - W'(1) : cnt_q;
        unb_d = load_i ? load_unb_i : unb_q;
    end

    // counter state, restarts at the reset-hold length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
            unb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            unb_q <= unb_d;
        end
    end

    assign last_o = (cnt_q == W'(1)) && !unb_q;
endmodule

// File: rtl/harness_run_ctrl.sv
// harness_run_ctrl: RESET/STEP/RUN_N/STOP sequencer owning the core's reset and clock-enable
// Optional breakpoint support when HARNESS_RUN_CTRL_BKPT_EN is defined.
module harness_run_ctrl
    import harness_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 4,
    parameter int          CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    harness_run_ctrl_if.slave cmd,
    input  logic [31:0]      iaddr,
    output logic             cpu_reset,
    output logic             cpu_ce,
    output logic             busy,
    output logic             done,
    output logic             cmd_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [31:0]      halt_pc
`ifdef HARNESS_RUN_CTRL_BKPT_EN
    ,
    input  logic             bkpt_en,
    input  logic [31:0]      bkpt_addr
`endif
);
    logic [1:0]       st_q, st_d;
    logic             busy_q, done_q, done_d, err_q, err_d, first_q;
    logic [CNT_W-1:0] cyc_q;
    logic [31:0]      halt_q;
    logic             acc, is_reset, bkpt_hit, last, ld, ld_unb;
    logic [CNT_W-1:0] ld_val;

    assign cmd.cmd_ready = st_q != ST_RST_HOLD;
    assign acc           = cmd.cmd_valid && cmd.cmd_ready;
    assign is_reset      = acc && cmd.cmd_op == OP_RESET;

`ifdef HARNESS_RUN_CTRL_BKPT_EN
    // the first RUN cycle ignores the match so a resume executes the breakpoint instruction
    assign bkpt_hit = st_q == ST_RUN && !first_q && bkpt_en && iaddr == bkpt_addr;
`else
    assign bkpt_hit = 1'b0;
`endif

    assign cpu_ce    = st_q == ST_RUN && !bkpt_hit;
    assign cpu_reset = st_q == ST_RST_HOLD;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_err   = err_q;
    assign cycle_cnt = cyc_q;
    assign halt_pc   = done_q ? iaddr : halt_q;

    // command decode and state transitions; the shared counter holds reset-hold or run length
    always_comb begin
        st_d   = st_q;
        done_d = 1'b0;
        err_d  = err_q;
        ld     = 1'b0;
        ld_val = CNT_W'(RST_CYCLES);
        ld_unb = 1'b0;
        if (st_q == ST_RST_HOLD) begin
            st_d = last ? ST_IDLE : ST_RST_HOLD;
        end else if (is_reset) begin
            st_d  = ST_RST_HOLD;
            err_d = 1'b0;
            ld    = 1'b1;
        end else if (st_q == ST_IDLE && acc) begin
            if (cmd.cmd_op == OP_STOP) begin
                err_d = 1'b1;
            end else begin
                st_d   = ST_RUN;
                ld     = 1'b1;
                ld_val = cmd.cmd_op == OP_STEP ? CNT_W'(1) : cmd.cmd_arg;
                ld_unb = cmd.cmd_op == OP_RUN_N && cmd.cmd_arg == '0;
            end
        end else if (st_q == ST_RUN) begin
            if (acc && (cmd.cmd_op == OP_STEP || cmd.cmd_op == OP_RUN_N)) err_d = 1'b1;
            if ((acc && cmd.cmd_op == OP_STOP) || bkpt_hit || (cpu_ce && last)) begin
                st_d   = ST_IDLE;
                done_d = 1'b1;
            end
        end
    end

    run_ctrl_counter #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(RST_CYCLES))
    ) u_cnt (
        .clk        (clk),
        .rst_n      (resetn),
        .load_i     (ld),
        .load_val_i (ld_val),
        .load_unb_i (ld_unb),
        .dec_i      (cpu_ce || st_q == ST_RST_HOLD),
        .last_o     (last)
    );

    // controller registers; busy is registered so it reads 0 while resetn is asserted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q    <= ST_RST_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            cyc_q   <= '0;
            halt_q  <= '0;
        end else begin
            st_q    <= st_d;
            busy_q  <= st_d != ST_IDLE;
            done_q  <= done_d;
            err_q   <= err_d;
            first_q <= st_q != ST_RUN;
            cyc_q   <= is_reset ? '0 : cyc_q + CNT_W'(cpu_ce);
            halt_q  <= halt_pc;
        end
    end
endmodule
